sprite_linebuf: RTL and testbench

SPRITE_LINEBUF -- requirements
Module: sprite_linebuf

---
 rtl/alpha_spr_pkg.sv | 15 +
 rtl/linebuf_dpram.sv | 40 ++++
 rtl/sprite_linebuf.sv | 171 +++++++++++++++++
 tb/tb_sprite_linebuf.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_spr_pkg.sv
// Shared defaults and FSM state type for the sprite line buffer.
// Bank RAM geometry and the pixel transparency mask live here so that benches can reuse them.
package alpha_spr_pkg;

   localparam int         XW_DEF     = 9;
   localparam int         PW_DEF     = 11;
   localparam logic [3:0] TMASK_DEF  = 4'hF;
   localparam int         BUDGET_DEF = 384;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/linebuf_dpram.sv
// Dual-port line RAM: port A write-only (render/sweep), port B read-first with clear write.
// dout_b only updates on an enabled read, so it holds the last pixel between reads.
module linebuf_dpram #(
   parameter int XW = 9,
   parameter int PW = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_a,
   input  logic [XW-1:0] addr_a,
   input  logic [PW-1:0] din_a,
   input  logic          en_b,
   input  logic          we_b,
   input  logic [XW-1:0] addr_b,
   input  logic [PW-1:0] din_b,
   output logic [PW-1:0] dout_b
);

   logic [PW-1:0] mem [2**XW];
   logic [PW-1:0] dout_b_q, dout_b_d;

   always_comb begin
      dout_b_d = dout_b_q;
      if (en_b) dout_b_d = mem[addr_b];
   end

   always_ff @(posedge clk) begin
      if (reset) dout_b_q <= '0;
      else       dout_b_q <= dout_b_d;
   end

   // Port B is written last so a clear wins over a same-address render write.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
   end

   assign dout_b = dout_b_q;

endmodule

// File: rtl/sprite_linebuf.sv
// Double-banked sprite line buffer: one bank is rendered from a pixel stream while
// the other is read (and cleared behind the read) by the display.
module sprite_linebuf
   import alpha_spr_pkg::*;
#(
   parameter int            XW     = XW_DEF,
   parameter int            PW     = PW_DEF,
   parameter logic [PW-1:0] TMASK  = PW'(TMASK_DEF),
   parameter int            BUDGET = BUDGET_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          line_start,
   input  logic          flip,
   input  logic          spr_load,
   input  logic [XW-1:0] spr_x,
   input  logic          spr_hflip,
   input  logic          pix_valid,
   input  logic [PW-1:0] pix_data,
   output logic          pix_ready,
   input  logic          rd_en,
   input  logic [XW-1:0] rd_x,
   output logic [PW-1:0] rd_pix,
   output logic          overrun,
   output logic          init_busy,
   output state_e        dbg_state
);

   localparam int CW = $clog2(BUDGET + 1);

   // Handshake: a pixel is consumed on a rising edge where pix_valid && pix_ready;
   // pix_ready drops for sweep, sprite-load and line-start cycles.

   state_e        state_q, state_d;
   logic [XW-1:0] init_addr_q, init_addr_d;
   logic          bank_sel_q, bank_sel_d;
   logic [XW-1:0] wx_q, wx_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          overrun_q, overrun_d;
   logic          clr_pend_q, clr_pend_d;
   logic          clr_bank_q, clr_bank_d;
   logic [XW-1:0] clr_addr_q, clr_addr_d;
   logic          rd_bank_q, rd_bank_d;

   logic          run, rd_go, accept, budget_ok, opaque, wr_en;
   logic [XW-1:0] rd_addr;
   logic [1:0]    we_a, en_b, we_b;
   logic [XW-1:0] addr_a, addr_b;
   logic [PW-1:0] din_a;
   logic [PW-1:0] dout_b [2];

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      bank_sel_d  = bank_sel_q;
      wx_d        = wx_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      overrun_d   = overrun_q;
      clr_pend_d  = 1'b0;
      clr_bank_d  = clr_bank_q;
      clr_addr_d  = clr_addr_q;
      rd_bank_d   = rd_bank_q;

      run       = (state_q == ST_RUN);
      rd_addr   = flip ? ~rd_x : rd_x;
      rd_go     = run && rd_en;
      pix_ready = run && !spr_load && !line_start;
      accept    = pix_valid && pix_ready;
      budget_ok = (cnt_q < CW'(BUDGET));
      opaque    = ((pix_data & TMASK) != '0);
      wr_en     = accept && opaque && budget_ok;

      case (state_q)
         ST_INIT: begin
            init_addr_d = init_addr_q + XW'(1);
            if (init_addr_q == {XW{1'b1}}) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (line_start) begin
               bank_sel_d = ~bank_sel_q;
               cnt_d      = '0;
               overrun_d  = 1'b0;
            end
            if (spr_load) begin
               wx_d  = spr_x;
               dir_d = spr_hflip;
            end else if (accept) begin
               wx_d = dir_q ? (wx_q - XW'(1)) : (wx_q + XW'(1));
               if (budget_ok) cnt_d     = cnt_q + CW'(1);
               else           overrun_d = 1'b1;
            end
            // The clear target is latched now so a bank swap next cycle cannot redirect it.
            if (rd_go) begin
               clr_pend_d = 1'b1;
               clr_bank_d = ~bank_sel_q;
               clr_addr_d = rd_addr;
               rd_bank_d  = ~bank_sel_q;
            end
         end
         default: state_d = ST_INIT;
      endcase

      if (!run) begin
         we_a   = 2'b11;
         addr_a = init_addr_q;
         din_a  = '0;
      end else begin
         we_a   = wr_en ? (bank_sel_q ? 2'b10 : 2'b01) : 2'b00;
         addr_a = wx_q;
         din_a  = pix_data;
      end

      en_b   = rd_go ? (bank_sel_q ? 2'b01 : 2'b10) : 2'b00;
      we_b   = clr_pend_q ? (clr_bank_q ? 2'b10 : 2'b01) : 2'b00;
      addr_b = clr_pend_q ? clr_addr_q : rd_addr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         bank_sel_q  <= 1'b0;
         wx_q        <= '0;
         dir_q       <= 1'b0;
         cnt_q       <= '0;
         overrun_q   <= 1'b0;
         clr_pend_q  <= 1'b0;
         clr_bank_q  <= 1'b0;
         clr_addr_q  <= '0;
         rd_bank_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         bank_sel_q  <= bank_sel_d;
         wx_q        <= wx_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         overrun_q   <= overrun_d;
         clr_pend_q  <= clr_pend_d;
         clr_bank_q  <= clr_bank_d;
         clr_addr_q  <= clr_addr_d;
         rd_bank_q   <= rd_bank_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      linebuf_dpram #(
         .XW (XW),
         .PW (PW)
      ) u_ram (
         .clk    (clk),
         .reset  (reset),
         .we_a   (we_a[b]),
         .addr_a (addr_a),
         .din_a  (din_a),
         .en_b   (en_b[b]),
         .we_b   (we_b[b]),
         .addr_b (addr_b),
         .din_b  ({PW{1'b0}}),
         .dout_b (dout_b[b])
      );
   end

   assign rd_pix    = rd_bank_q ? dout_b[1] : dout_b[0];
   assign overrun   = overrun_q;
   assign init_busy = (state_q == ST_INIT);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: a default instance and a BUDGET=4 instance share all stimulus;
// read results go through expected queues and are compared one cycle after the request.
module tb_sprite_linebuf;
   import alpha_spr_pkg::*;

   localparam int XW = 9;
   localparam int PW = 11;

   // ---------------- clock / reset / DUTs ----------------
   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, line_start, flip, spr_load, spr_hflip, pix_valid, rd_en;
   logic [XW-1:0] spr_x, rd_x;
   logic [PW-1:0] pix_data;
   logic          pix_ready, overrun, init_busy;
   logic          pix_ready_b, overrun_b, init_busy_b;
   logic [PW-1:0] rd_pix, rd_pix_b;
   state_e        dbg_state, dbg_state_b;

   sprite_linebuf u_dut (
      .clk (clk), .reset (reset), .line_start (line_start), .flip (flip),
      .spr_load (spr_load), .spr_x (spr_x), .spr_hflip (spr_hflip),
      .pix_valid (pix_valid), .pix_data (pix_data), .pix_ready (pix_ready),
      .rd_en (rd_en), .rd_x (rd_x), .rd_pix (rd_pix), .overrun (overrun),
      .init_busy (init_busy), .dbg_state (dbg_state)
   );

   sprite_linebuf #(.BUDGET(4)) u_dut_b (
      .clk (clk), .reset (reset), .line_start (line_start), .flip (flip),
      .spr_load (spr_load), .spr_x (spr_x), .spr_hflip (spr_hflip),
      .pix_valid (pix_valid), .pix_data (pix_data), .pix_ready (pix_ready_b),
      .rd_en (rd_en), .rd_x (rd_x), .rd_pix (rd_pix_b), .overrun (overrun_b),
      .init_busy (init_busy_b), .dbg_state (dbg_state_b)
   );

   // ---------------- scoreboard and reference model ----------------
   int            total = 0;
   int            bad   = 0;
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] expb_q[$];
   logic [PW-1:0] mdl  [2][512];
   logic [PW-1:0] mdlb [2][512];
   logic          m_sel, m_dir;
   logic [XW-1:0] m_wx;
   int            m_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      line_start = 0; flip = 0; spr_load = 0; spr_x = '0; spr_hflip = 0;
      pix_valid = 0; pix_data = '0; rd_en = 0; rd_x = '0;
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      repeat (n) tick();
      reset = 0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 512; a++) begin
            mdl[b][a]  = '0;
            mdlb[b][a] = '0;
         end
      m_sel = 0; m_dir = 0; m_wx = '0; m_cnt = 0;
   endtask

   task automatic wait_init(input string nm);
      int n = 0;
      while (init_busy && n < 2000) begin
         n++;
         tick();
      end
      chk({nm, " init cycles"}, n, 512);
      chk({nm, " init_busy_b"}, init_busy_b, 0);
      chk({nm, " pix_ready after init"}, pix_ready, 1);
      chk({nm, " state run"}, dbg_state, ST_RUN);
   endtask

   task automatic model_accept(input logic [PW-1:0] d);
      if (d[3:0] != 4'h0 && m_cnt < 384) mdl[m_sel][m_wx] = d;
      if (d[3:0] != 4'h0 && m_cnt < 4)   mdlb[m_sel][m_wx] = d;
      m_cnt++;
      m_wx = m_dir ? m_wx - 9'd1 : m_wx + 9'd1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_load(input logic [XW-1:0] x, input logic h);
      spr_load = 1; spr_x = x; spr_hflip = h;
      tick();
      spr_load = 0;
      m_wx = x; m_dir = h;
   endtask

   task automatic send_pix(input logic [PW-1:0] d);
      pix_valid = 1; pix_data = d;
      #1;
      chk("pix_ready", pix_ready, 1);
      tick();
      pix_valid = 0;
      model_accept(d);
   endtask

   task automatic swap();
      line_start = 1;
      tick();
      line_start = 0;
      m_sel = ~m_sel;
      m_cnt = 0;
   endtask

   task automatic do_read(input logic [XW-1:0] x, input logic f,
                          input logic [PW-1:0] e, input logic [PW-1:0] eb, input string nm);
      logic [XW-1:0] a;
      a = f ? ~x : x;
      rd_en = 1; rd_x = x; flip = f;
      exp_q.push_back(e);
      expb_q.push_back(eb);
      mdl[~m_sel][a]  = '0;
      mdlb[~m_sel][a] = '0;
      tick();
      rd_en = 0; flip = 0;
      if (exp_q.size() > 0)  chk(nm, rd_pix, exp_q.pop_front());
      if (expb_q.size() > 0) chk({nm, " b"}, rd_pix_b, expb_q.pop_front());
      tick();
   endtask

   task automatic read_mdl(input logic [XW-1:0] x, input logic f, input string nm);
      logic [XW-1:0] a;
      a = f ? ~x : x;
      do_read(x, f, mdl[~m_sel][a], mdlb[~m_sel][a], nm);
   endtask

   // ---------------- read-vector table ----------------
   typedef struct {
      logic [XW-1:0] x;
      logic          f;
      logic [PW-1:0] e;
      logic [PW-1:0] eb;
   } rvec_t;

   rvec_t tab [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] d;
      logic          f;

      tab[0] = '{9'd510, 1'b0, 11'd1, 11'd1};
      tab[1] = '{9'd511, 1'b0, 11'd2, 11'd2};
      tab[2] = '{9'd0,   1'b0, 11'd3, 11'd3};
      tab[3] = '{9'd1,   1'b0, 11'd4, 11'd4};
      tab[4] = '{9'd20,  1'b0, 11'd5, 11'd0};
      tab[5] = '{9'd19,  1'b0, 11'd0, 11'd0};
      tab[6] = '{9'd18,  1'b0, 11'd7, 11'd0};
      tab[7] = '{9'd2,   1'b0, 11'd0, 11'd0};
      tab[8] = '{9'd21,  1'b0, 11'd0, 11'd0};
      tab[9] = '{9'd1,   1'b1, 11'd0, 11'd0};

      idle_inputs();
      do_reset(3);
      chk("reset init_busy", init_busy, 1);
      chk("reset pix_ready", pix_ready, 0);
      chk("reset rd_pix", rd_pix, 0);
      chk("reset overrun", overrun, 0);
      chk("reset state", dbg_state, ST_INIT);

      // rd_en during the sweep must be ignored, then a reset mid-sweep restarts it.
      repeat (50) tick();
      rd_en = 1; rd_x = 9'd300;
      tick();
      rd_en = 0;
      tick();
      chk("init rd ignored", rd_pix, 0);
      chk("init pix_ready", pix_ready, 0);
      repeat (40) tick();
      do_reset(1);
      wait_init("restart");

      do_read(9'd0, 0, 0, 0, "post-init rd 0");
      do_read(9'd255, 0, 0, 0, "post-init rd 255");
      do_read(9'd511, 1, 0, 0, "post-init rd flip");

      // Wrapping forward strip, then a reversed strip with a transparent pixel.
      do_load(9'd510, 0);
      send_pix(11'd1); send_pix(11'd2); send_pix(11'd3); send_pix(11'd4);
      do_load(9'd20, 1);
      send_pix(11'd5); send_pix(11'h10); send_pix(11'd7);
      chk("lineA overrun", overrun, 0);
      chk("lineA overrun_b", overrun_b, 1);
      swap();
      chk("lineA overrun_b cleared", overrun_b, 0);
      for (int i = 0; i < 10; i++)
         do_read(tab[i].x, tab[i].f, tab[i].e, tab[i].eb, $sformatf("tab[%0d]", i));

      // Budget exhaustion on the BUDGET=4 instance.
      do_load(9'd0, 0);
      for (int i = 1; i <= 6; i++) send_pix(PW'(i));
      repeat (3) tick();
      chk("budget overrun_b", overrun_b, 1);
      chk("budget overrun", overrun, 0);
      swap();
      chk("budget overrun_b after swap", overrun_b, 0);
      for (int i = 0; i < 6; i++)
         do_read(XW'(i), 0, PW'(i + 1), (i < 4) ? PW'(i + 1) : PW'(0), $sformatf("budget rd %0d", i));

      // Read latency, hold, clear-after-read and flipped addressing.
      do_load(9'd100, 0);
      send_pix(11'd9);
      swap();
      do_read(9'd100, 0, 11'd9, 11'd9, "rd 100");
      repeat (3) tick();
      chk("rd_pix hold", rd_pix, 11'd9);
      do_read(9'd100, 0, 11'd0, 11'd0, "re-rd 100");
      do_load(9'd100, 0);
      send_pix(11'h19);
      swap();
      do_read(9'd411, 1, 11'h19, 11'h19, "flip rd 411");

      // Load beats a same-cycle pixel; a pixel during line_start is refused.
      spr_load = 1; spr_x = 9'd300; spr_hflip = 0; pix_valid = 1; pix_data = 11'h0F;
      #1;
      chk("load+pix ready", pix_ready, 0);
      tick();
      spr_load = 0; pix_valid = 0;
      m_wx = 9'd300; m_dir = 0;
      send_pix(11'h21);
      line_start = 1; pix_valid = 1; pix_data = 11'h33;
      #1;
      chk("line_start ready", pix_ready, 0);
      tick();
      line_start = 0; pix_valid = 0;
      m_sel = ~m_sel; m_cnt = 0;
      do_read(9'd300, 0, 11'h21, 11'h21, "rd 300");
      do_read(9'd301, 0, 11'h00, 11'h00, "rd 301 empty");
      send_pix(11'h44);
      swap();
      do_read(9'd301, 0, 11'h44, 11'h44, "wx kept 301");
      do_read(9'd302, 0, 11'h00, 11'h00, "rd 302 empty");
      do_read(9'd300, 0, 11'h00, 11'h00, "rd 300 empty");

      // Random lines checked against the reference model, full-line readback.
      for (int ln = 0; ln < 3; ln++) begin
         do_load(XW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 5) == 0)
               do_load(XW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            d = PW'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) == 0) d[3:0] = 4'h0;
            send_pix(d);
         end
         swap();
         f = 1'($urandom_range(0, 1));
         for (int x = 0; x < 512; x++)
            read_mdl(XW'(x), f, $sformatf("rand line %0d x %0d", ln, x));
      end

      chk("queue drained", exp_q.size() + expb_q.size(), 0);
      chk("final overrun", overrun, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
